esdi_drive_cmd_responder: RTL
=============================

ESDI_DRIVE_CMD_RESPONDER -- requirements
Module: esdi_drive_cmd_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 4: clk cycles from synchronized REQ edge to ACK change (min 1).
REQ-002 SHALL have parameter BIT_TIMEOUT, default 65535: idle cycles tolerated between bits of one word.
REQ-003 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- esdi_transfer_req  in  1  host TRANSFER REQ, asynchronous, logical active-high.
- esdi_command_data  in  1  host COMMAND DATA bit, asynchronous.
- esdi_transfer_ack  out  1  drive TRANSFER ACK, active-high.
- esdi_confstat_data  out  1  drive CONFIG/STATUS data bit.
- cmd_word  out  16  last received command word.
- cmd_valid  out  1  one-cycle pulse: cmd_word is updated.
- cmd_parity_err  out  1  sticky, cleared on next cmd_valid: parity error on last command.
- cmd_timeout  out  1  one-cycle pulse: word aborted by timeout.
- resp_word  in  16  status/config word to return.
- resp_valid  in  1  resp_word is valid; held until resp_ready.
- resp_ready  out  1  one-cycle pulse: resp_word is captured.

Function
REQ-004 SHALL pass esdi_transfer_req and esdi_command_data through 2-flop synchronizers; all logic uses the synchronized copies.
REQ-005 SHALL implement states IDLE, CMD_ACK, CMD_REL, CMD_DONE, RESP_WAIT, RESP_SETUP, RESP_ACK, RESP_REL.
REQ-006 Command word: 17 bits, bit 15 first, bit 0, then an odd-parity bit (ones count over all 17 bits SHALL be odd).
REQ-007 IDLE/CMD_REL: on synchronized REQ rise, SHALL sample command_data into a shift register, wait ACK_DELAY cycles, then assert ack (CMD_ACK).
REQ-008 CMD_ACK: on REQ fall, SHALL wait ACK_DELAY cycles, deassert ack, and increment the 5-bit bit counter (CMD_REL).
REQ-009 After the 17th bit handshake completes, SHALL load cmd_word, pulse cmd_valid one cycle later, and set cmd_parity_err if the parity check fails (CMD_DONE).
REQ-010 CMD_DONE -> RESP_WAIT; a word with a parity error SHALL still advance to the response phase.
REQ-011 RESP_WAIT: SHALL hold ack low and ignore REQ until resp_valid; then capture resp_word with a resp_ready pulse and compute odd parity.
REQ-012 Response: 17 bits, same order and parity as REQ-006. For each bit, on REQ rise (RESP_SETUP) SHALL drive confstat_data, wait ACK_DELAY cycles, assert ack (RESP_ACK); on REQ fall, wait ACK_DELAY, deassert ack (RESP_REL).
REQ-013 confstat_data SHALL be stable from at least ACK_DELAY cycles before the ack rise until the ack fall.
REQ-014 After the 17th response bit is released, SHALL return to IDLE with confstat_data=0.
REQ-015 REQ already high when RESP_WAIT exits SHALL be treated as a rising edge for response bit 0.
REQ-016 The bit counter SHALL saturate-check at 17 and never wrap into a new word without passing IDLE.
REQ-017 Glitch: a REQ pulse shorter than the synchronizer depth may be missed; no partial ack SHALL be emitted.

Reset
REQ-018 On rst: state=IDLE; transfer_ack=0, confstat_data=0, cmd_word=0, cmd_valid=0, cmd_parity_err=0, cmd_timeout=0, resp_ready=0; counters and synchronizers cleared.
REQ-019 Reset mid-word SHALL discard the partial word; the first REQ rise after reset is command bit 15.

Configuration
REQ-020 Macro ESDI_RESP_TIMEOUT_EN: when defined, a 16-bit counter SHALL run in CMD_REL and RESP_REL states with bit counter >0 (and in RESP_SETUP awaiting REQ). On reaching BIT_TIMEOUT it SHALL pulse cmd_timeout, clear ack and confstat_data, and go to IDLE.
REQ-021 Without ESDI_RESP_TIMEOUT_EN, there SHALL be no counter, the block SHALL wait indefinitely, and cmd_timeout SHALL be tied 0.

Verification
REQ-022 Host sends 0xA5C3 with correct odd parity -> cmd_valid pulse, cmd_word=0xA5C3, cmd_parity_err=0, 17 ack handshakes each ACK_DELAY+2 cycles after REQ edge.
REQ-023 Host sends 0x0001 with wrong parity -> cmd_valid, cmd_parity_err=1; next good command clears it.
REQ-024 resp_valid with 0x8000 asserted 100 cycles after the command -> no ack until resp_ready; host reads 17 bits = 0x8000 + parity bit 0.
REQ-025 rst asserted after 8 command bits -> all outputs 0 immediately; next 17-bit word is received correctly.
REQ-026 With ESDI_RESP_TIMEOUT_EN, BIT_TIMEOUT=100, host stalls after bit 5 -> cmd_timeout pulse at cycle 100, ack=0, state IDLE.

Source files
------------

// File: rtl/esdi_drive_cmd_responder.sv
// ---------------------------------------------------------------------------
// esdi_drive_cmd_responder
//
// Drive side of the ESDI serial command / configuration-status handshake.
// The host shifts a 17-bit command in with TRANSFER REQ / TRANSFER ACK
// handshakes. The order is bit 15 first, then down to bit 0, then an odd
// parity bit. The block then waits for a local status word. That word is
// returned over the same handshake on CONFIG/STATUS DATA, in the same order
// and with the same parity rule.
//
// Parameters
//   ACK_DELAY    clk cycles from a synchronized REQ edge to the ACK change (>= 1)
//   BIT_TIMEOUT  idle cycles tolerated between bits when the timeout is built in
//
// Ports
//   clk                 sole clock
//   rst                 asynchronous active-high reset
//   esdi_transfer_req   host TRANSFER REQ (asynchronous)
//   esdi_command_data   host COMMAND DATA bit (asynchronous)
//   esdi_transfer_ack   drive TRANSFER ACK
//   esdi_confstat_data  drive CONFIG/STATUS data bit
//   cmd_word            last received command word
//   cmd_valid           one-cycle pulse when cmd_word is updated
//   cmd_parity_err      parity error on the last command; held until the next cmd_valid
//   cmd_timeout         one-cycle pulse when a word is aborted by the bit timeout
//   resp_word           status/config word to return
//   resp_valid          resp_word is valid; held by the user until resp_ready
//   resp_ready          one-cycle pulse when resp_word is captured
//
// Build option
//   ESDI_RESP_TIMEOUT_EN  When this is defined, an inter-bit timeout aborts a
//                         stalled word. Without it the block waits forever and
//                         cmd_timeout is constant 0.
// ---------------------------------------------------------------------------
module esdi_drive_cmd_responder #(
  parameter int unsigned ACK_DELAY   = 4,
  parameter int unsigned BIT_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        esdi_transfer_req,
  input  logic        esdi_command_data,
  output logic        esdi_transfer_ack,
  output logic        esdi_confstat_data,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  output logic        cmd_parity_err,
  output logic        cmd_timeout,
  input  logic [15:0] resp_word,
  input  logic        resp_valid,
  output logic        resp_ready
);

  typedef enum logic [2:0] {
    IDLE, CMD_ACK, CMD_REL, CMD_DONE, RESP_WAIT, RESP_SETUP, RESP_ACK, RESP_REL
  } state_t;

  localparam int unsigned      DLY_W    = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ACK_DELAY - 1);
  localparam logic [4:0]       WORD_BITS = 5'd17;

  state_t            state_q, state_d;
  logic              req_meta_q, req_sync_q, dat_meta_q, dat_sync_q;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [16:0]       cmd_sr_q, cmd_sr_d;
  logic [16:0]       resp_sr_q, resp_sr_d;
  logic              ack_q, ack_d;
  logic [15:0]       cmd_word_q, cmd_word_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              perr_q, perr_d;
  logic              resp_ready_q, resp_ready_d;

`ifdef ESDI_RESP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(BIT_TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_pulse_q, tmo_pulse_d;
  logic        bit_wait;

  // The counter runs only while the host owes us the next REQ rise in the middle of a word.
  assign bit_wait = !req_sync_q &&
                    ((state_q == CMD_REL && bit_cnt_q != 5'd0) || state_q == RESP_SETUP);
  assign cmd_timeout = tmo_pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end
`else
  // The timeout is absent; the term keeps BIT_TIMEOUT referenced so the parameter list is the same in both builds.
  assign cmd_timeout = 1'b0 & (BIT_TIMEOUT != 0);
`endif

  // Both host lines go through two flops; nothing downstream looks at the raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      req_meta_q <= esdi_transfer_req;
      req_sync_q <= req_meta_q;
      dat_meta_q <= esdi_command_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dly_q        <= '0;
      bit_cnt_q    <= '0;
      cmd_sr_q     <= '0;
      resp_sr_q    <= '0;
      ack_q        <= 1'b0;
      cmd_word_q   <= '0;
      cmd_valid_q  <= 1'b0;
      perr_q       <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_sr_q     <= cmd_sr_d;
      resp_sr_q    <= resp_sr_d;
      ack_q        <= ack_d;
      cmd_word_q   <= cmd_word_d;
      cmd_valid_q  <= cmd_valid_d;
      perr_q       <= perr_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  // The REQ level being waited on must hold for ACK_DELAY consecutive cycles
  // before ACK moves. A shorter pulse resets dly, so a glitch never produces a partial ack.
  always_comb begin
    state_d      = state_q;
    dly_d        = '0;
    bit_cnt_d    = bit_cnt_q;
    cmd_sr_d     = cmd_sr_q;
    resp_sr_d    = resp_sr_q;
    ack_d        = ack_q;
    cmd_word_d   = cmd_word_q;
    cmd_valid_d  = 1'b0;
    perr_d       = perr_q;
    resp_ready_d = 1'b0;
`ifdef ESDI_RESP_TIMEOUT_EN
    tmo_d        = '0;
    tmo_pulse_d  = 1'b0;
`endif

    case (state_q)
      IDLE, CMD_REL, RESP_SETUP: begin
        if (req_sync_q) begin
          if (dly_q != DLY_LAST) begin
            dly_d = dly_q + DLY_W'(1);
          end else begin
            ack_d = 1'b1;
            if (state_q == RESP_SETUP) begin
              state_d = RESP_ACK;
            end else begin
              // The command bit is taken as ACK rises; by then it has settled through its own synchronizer.
              state_d  = CMD_ACK;
              cmd_sr_d = {cmd_sr_q[15:0], dat_sync_q};
            end
          end
        end
      end

      CMD_ACK, RESP_ACK: begin
        if (!req_sync_q) begin
          if (dly_q != DLY_LAST) begin
            dly_d = dly_q + DLY_W'(1);
          end else begin
            ack_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (state_q == RESP_ACK)
              state_d = RESP_REL;
            else if (bit_cnt_q >= WORD_BITS - 5'd1)
              state_d = CMD_DONE;
            else
              state_d = CMD_REL;
          end
        end
      end

      CMD_DONE: begin
        // cmd_sr holds {bit15..bit0, parity}. An even ones count over all 17 bits is an error.
        cmd_word_d  = cmd_sr_q[16:1];
        perr_d      = ~^cmd_sr_q;
        cmd_valid_d = 1'b1;
        bit_cnt_d   = '0;
        state_d     = RESP_WAIT;
      end

      RESP_WAIT: begin
        // REQ is ignored here. A REQ that is already high is seen as the
        // bit-0 rise as soon as RESP_SETUP is entered.
        if (resp_valid) begin
          resp_ready_d = 1'b1;
          resp_sr_d    = {resp_word, ~^resp_word};
          state_d      = RESP_SETUP;
        end
      end

      RESP_REL: begin
        // The next bit is presented one cycle after ACK falls. The host
        // cannot raise REQ again sooner, so the data leads the next ACK rise
        // by at least ACK_DELAY cycles.
        if (bit_cnt_q >= WORD_BITS) begin
          bit_cnt_d = '0;
          resp_sr_d = '0;
          state_d   = IDLE;
        end else begin
          resp_sr_d = {resp_sr_q[15:0], 1'b0};
          state_d   = RESP_SETUP;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef ESDI_RESP_TIMEOUT_EN
    if (bit_wait) begin
      if (tmo_q == TMO_LAST) begin
        tmo_pulse_d = 1'b1;
        ack_d       = 1'b0;
        resp_sr_d   = '0;
        bit_cnt_d   = '0;
        dly_d       = '0;
        state_d     = IDLE;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
`endif
  end

  assign esdi_transfer_ack  = ack_q;
  assign esdi_confstat_data = resp_sr_q[16];
  assign cmd_word           = cmd_word_q;
  assign cmd_valid          = cmd_valid_q;
  assign cmd_parity_err     = perr_q;
  assign resp_ready         = resp_ready_q;

endmodule
